// File: rtl/kamus_dmem_ctrl.sv
// LSU-to-data-bus request controller: one access in flight, 3-cycle accept-to-response on a zero-wait bus.
// LSU is only granted in IDLE; bus requests hold stable until dmem_gnt_i; a watchdog bounds stalls.
package kamus_pkg;
    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_width_t;
endpackage

module kamus_dmem_ctrl
    import kamus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  mem_width_t  lsu_width_i,
    input  logic        lsu_unsigned_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        lsu_busy_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    localparam bit          LP_WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] LP_TO_LAST = LP_WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_unsigned;
    mem_width_t  r_width;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [15:0] r_cnt;

    logic        w_accept;
    logic        w_illegal;
    logic [3:0]  w_be;
    logic [1:0]  w_off;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic        w_timeout;

    assign w_off      = lsu_addr_i[1:0];
    assign w_accept   = (r_state == S_IDLE) & lsu_req_i & ~rst_i;
    assign w_wdata_sh = lsu_wdata_i << {w_off, 3'b000};
    assign w_shifted  = dmem_rdata_i >> {r_off, 3'b000};
    // Counter starts at 0 in the first REQ cycle, so LP_TO_LAST marks the last allowed cycle.
    assign w_timeout  = LP_WD_EN && (r_cnt >= LP_TO_LAST);

    always_comb begin
        w_illegal = 1'b0;
        w_be      = 4'b0000;
        case (lsu_width_i)
            MEM_B: w_be = 4'b0001 << w_off;
            MEM_H: begin
                w_be      = 4'b0011 << w_off;
                w_illegal = w_off[0];
            end
            MEM_W: begin
                w_be      = 4'b1111;
                w_illegal = |w_off;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_load = w_shifted;
        case (r_width)
            MEM_B:   w_load = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            MEM_H:   w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_illegal ? S_RESP : S_REQ;
            S_REQ: begin
                if (dmem_gnt_i)     w_next = S_WAIT;
                else if (w_timeout) w_next = S_RESP;
            end
            S_WAIT: begin
                if (dmem_rvalid_i)  w_next = S_RESP;
                else if (w_timeout) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_width    <= MEM_B;
            r_off      <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we       <= lsu_we_i;
                        r_unsigned <= lsu_unsigned_i;
                        r_width    <= lsu_width_i;
                        r_off      <= w_off;
                        r_addr     <= {lsu_addr_i[31:2], 2'b00};
                        r_wdata    <= w_wdata_sh;
                        r_be       <= w_be;
                        r_rdata    <= '0;
                        r_err      <= w_illegal;
                        r_cnt      <= '0;
                    end
                end
                S_REQ: begin
                    if (LP_WD_EN) r_cnt <= r_cnt + 16'd1;
                    if (!dmem_gnt_i && w_timeout) r_err <= 1'b1;
                end
                S_WAIT: begin
                    if (LP_WD_EN) r_cnt <= r_cnt + 16'd1;
                    if (dmem_rvalid_i) begin
                        r_rdata <= (r_we | dmem_err_i) ? 32'd0 : w_load;
                        r_err   <= dmem_err_i;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lsu_gnt_o    = w_accept;
    assign lsu_rvalid_o = (r_state == S_RESP);
    assign lsu_rdata_o  = r_rdata;
    assign lsu_err_o    = r_err;
    assign lsu_busy_o   = (r_state != S_IDLE);
    assign dmem_req_o   = (r_state == S_REQ);
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

endmodule

// File: tb/tb_kamus_dmem_ctrl.sv
// Self-checking bench for kamus_dmem_ctrl: scoreboard of expected LSU responses plus per-scenario bus checks.
module tb_kamus_dmem_ctrl;
    import kamus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we, lsu_unsigned;
    logic [31:0] lsu_addr, lsu_wdata;
    mem_width_t  lsu_width;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o, lsu_busy_o;
    logic [31:0] lsu_rdata_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;
    exp_t sb[$];

    kamus_dmem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_width_i(lsu_width), .lsu_unsigned_i(lsu_unsigned),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_o(lsu_err_o), .lsu_busy_o(lsu_busy_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .dmem_err_i(dmem_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every lsu_rvalid_o must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && lsu_rvalid_o) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid cycle=%0d rdata=%h err=%b", cyc, lsu_rdata_o, lsu_err_o);
            end else begin
                e = sb.pop_front();
                if (lsu_rdata_o !== e.rdata || lsu_err_o !== e.err || cyc != e.at) begin
                    failures++;
                    $display("FAIL response got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                             lsu_rdata_o, lsu_err_o, cyc, e.rdata, e.err, e.at);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input mem_width_t w, input logic uns,
                         input logic [31:0] er, input logic ee, input int lat);
        exp_t e;
        lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
        lsu_width = w; lsu_unsigned = uns;
        #1;
        checks++;
        if (lsu_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL lsu_gnt addr=%h got=%b expected=1", addr, lsu_gnt_o);
        end
        e.rdata = er; e.err = ee; e.at = cyc + lat;
        sb.push_back(e);
        step();
        lsu_req = 1'b0;
    endtask

    task automatic bus_cycle(input int gnt_stall, input int rv_stall,
                             input logic [31:0] rd, input logic er);
        repeat (gnt_stall) step();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        repeat (rv_stall) step();
        dmem_rvalid = 1'b1; dmem_rdata = rd; dmem_err = er;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout missing=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lsu_req = 1'b1; lsu_width = MEM_W; lsu_addr = 32'h1234_5678; lsu_wdata = 32'hFFFF_FFFF;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) step();
        checks++;
        if ({lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o, lsu_busy_o} !== 36'd0) begin
            failures++;
            $display("FAIL reset_lsu_outputs got=%h expected=0",
                     {lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o, lsu_busy_o});
        end
        checks++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== 70'd0) begin
            failures++;
            $display("FAIL reset_dmem_outputs got=%h expected=0",
                     {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o});
        end
        lsu_req = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_lb_signed();
        issue(1'b0, 32'h0000_1003, 32'd0, MEM_B, 1'b0, 32'hFFFF_FF80, 1'b0, 3);
        checks++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o} !== {1'b1, 1'b0, 32'h0000_1000, 4'b1000}) begin
            failures++;
            $display("FAIL lb_request got req=%b we=%b addr=%h be=%b expected req=1 we=0 addr=00001000 be=1000",
                     dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o);
        end
        lsu_req = 1'b1;
        #1;
        checks++;
        if (lsu_gnt_o !== 1'b0 || lsu_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_gnt got gnt=%b busy=%b expected gnt=0 busy=1", lsu_gnt_o, lsu_busy_o);
        end
        lsu_req = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        checks++;
        if (dmem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL lb_req_drop got=%b expected=0", dmem_req_o);
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h8000_0000;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        drain();
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        mem_width_t  w;
        logic        uns;
        logic [31:0] bus;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] res;
    } vec_t;

    task automatic test_back_to_back();
        vec_t v[6];
        int   last = 0;
        v[0] = '{1'b0, 32'h2002, 32'h0, MEM_H, 1'b1, 32'hBEEF_1234, 4'b1100, 32'h0, 32'h0000_BEEF};
        v[1] = '{1'b0, 32'h2002, 32'h0, MEM_H, 1'b0, 32'hBEEF_1234, 4'b1100, 32'h0, 32'hFFFF_BEEF};
        v[2] = '{1'b0, 32'h4001, 32'h0, MEM_B, 1'b0, 32'h0000_AB00, 4'b0010, 32'h0, 32'hFFFF_FFAB};
        v[3] = '{1'b0, 32'h1003, 32'h0, MEM_B, 1'b1, 32'h8000_0000, 4'b1000, 32'h0, 32'h0000_0080};
        v[4] = '{1'b0, 32'h7000, 32'h0, MEM_W, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D};
        v[5] = '{1'b1, 32'h7001, 32'hEE, MEM_B, 1'b0, 32'h5555_5555, 4'b0010, 32'h0000_EE00, 32'h0};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                checks++;
                if (cyc - last != 4) begin
                    failures++;
                    $display("FAIL throughput vec=%0d spacing=%0d expected=4", i, cyc - last);
                end
            end
            last = cyc;
            issue(v[i].we, v[i].addr, v[i].wdata, v[i].w, v[i].uns, v[i].res, 1'b0, 3);
            checks++;
            if ({dmem_we_o, dmem_addr_o, dmem_be_o} !== {v[i].we, v[i].addr & 32'hFFFF_FFFC, v[i].be} ||
                (v[i].we && dmem_wdata_o !== v[i].bwdata)) begin
                failures++;
                $display("FAIL b2b_request vec=%0d got we=%b addr=%h be=%b wdata=%h expected be=%b wdata=%h",
                         i, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, v[i].be, v[i].bwdata);
            end
            bus_cycle(0, 0, v[i].bus, 1'b0);
            drain();
        end
    endtask

    task automatic test_sh_stall();
        issue(1'b1, 32'h0000_3002, 32'h0000_ABCD, MEM_H, 1'b0, 32'd0, 1'b0, 8);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !==
                {1'b1, 1'b1, 32'h0000_3000, 4'b1100, 32'hABCD_0000}) begin
                failures++;
                $display("FAIL sh_stable stall=%0d got req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 00003000 1100 abcd0000",
                         i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
            end
            step();
        end
        bus_cycle(0, 0, 32'hFFFF_FFFF, 1'b0);
        drain();
    endtask

    task automatic test_misaligned();
        mem_width_t bad;
        bad = mem_width_t'(2'b11);
        issue(1'b0, 32'h0000_4001, 32'd0, MEM_W, 1'b0, 32'd0, 1'b1, 1);
        checks++;
        if (dmem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL lw_misaligned_req got=%b expected=0", dmem_req_o);
        end
        drain();
        issue(1'b0, 32'h0000_4003, 32'd0, MEM_H, 1'b1, 32'd0, 1'b1, 1);
        drain();
        issue(1'b0, 32'h0000_4000, 32'd0, bad, 1'b0, 32'd0, 1'b1, 1);
        checks++;
        if (dmem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL bad_width_req got=%b expected=0", dmem_req_o);
        end
        drain();
    endtask

    task automatic test_watchdog();
        issue(1'b0, 32'h0000_5000, 32'd0, MEM_W, 1'b0, 32'd0, 1'b1, 9);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        repeat (8) step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        step();
        checks++;
        if (lsu_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL wd_late_rvalid busy got=%b expected=0", lsu_busy_o);
        end
        drain();
        issue(1'b0, 32'h0000_5004, 32'd0, MEM_W, 1'b0, 32'd0, 1'b1, 9);
        repeat (7) step();
        checks++;
        if (dmem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL wd_req_last_cycle got=%b expected=1", dmem_req_o);
        end
        step();
        checks++;
        if (dmem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL wd_req_drop got=%b expected=0", dmem_req_o);
        end
        drain();
        issue(1'b0, 32'h0000_5008, 32'd0, MEM_W, 1'b0, 32'h1122_3344, 1'b0, 9);
        bus_cycle(0, 6, 32'h1122_3344, 1'b0);
        drain();
    endtask

    task automatic test_bus_err();
        issue(1'b0, 32'h0000_6000, 32'd0, MEM_W, 1'b0, 32'd0, 1'b1, 3);
        bus_cycle(0, 0, 32'h1234_5678, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h0000_8000, 32'd0, MEM_W, 1'b0, 32'd0, 1'b0, 3);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        lsu_req = 1'b1;
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o, lsu_busy_o,
             dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== 106'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got busy=%b gnt=%b addr=%h be=%b expected all 0",
                     lsu_busy_o, lsu_gnt_o, dmem_addr_o, dmem_be_o);
        end
        step();
        lsu_req = 1'b0;
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) step();
        checks++;
        if (lsu_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle busy got=%b expected=0", lsu_busy_o);
        end
        issue(1'b0, 32'h0000_8004, 32'd0, MEM_W, 1'b0, 32'hA5A5_A5A5, 1'b0, 3);
        bus_cycle(0, 0, 32'hA5A5_A5A5, 1'b0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        lsu_width = MEM_B; lsu_unsigned = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
        rst = 1'b1;
        test_reset();
        test_lb_signed();
        test_back_to_back();
        test_sh_stall();
        test_misaligned();
        test_watchdog();
        test_bus_err();
        test_reset_mid();
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
